// File: rtl/acc_pkg.sv
// acc_pkg: accelerator instruction word, queue depth default and barrier classification.
package acc_pkg;
  localparam int ACC_QUEUE_DEPTH = 4;
  typedef enum logic [2:0] {OP_FADD, OP_FMUL, OP_FDIV, OP_SET_W, OP_PREPIV, OP_PIV} acc_opcode_e;
  typedef struct packed {
    logic        acc_op;
    acc_opcode_e op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } acc_instr_t;
  function automatic logic is_barrier_op(input acc_instr_t i);
    return i.acc_op;
  endfunction
endpackage

// File: rtl/acc_fifo.sv
// acc_fifo: generic synchronous circular-buffer FIFO with flush and occupancy count.
module acc_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 data_i,
  output logic [W-1:0]                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  assign full_o  = r_count == CW'(DEPTH);
  assign empty_o = r_count == '0;
  assign w_push  = push_i && !full_o && !flush_i;
  assign w_pop   = pop_i && !empty_o && !flush_i;
  assign data_o  = r_mem[r_rptr];
  assign count_o = r_count;
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wptr] <= data_i;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/acc_instr_queue.sv
// acc_instr_queue: issue buffer ahead of the accelerator controller with an FPU
// drain barrier and one-cycle bubble after accelerator ops.
module acc_instr_queue
  import acc_pkg::*;
#(
  parameter int DEPTH = ACC_QUEUE_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  acc_instr_t                 instr_i,
  input  logic                       instr_valid_i,
  output logic                       instr_ready_o,
  input  logic                       flush_i,
  output acc_instr_t                 acc_instr_o,
  output logic                       acc_instr_valid_o,
  input  logic                       acc_idle_i,
  input  logic                       fpu_busy_i,
  input  logic                       fpu_in_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       empty_o,
  output logic                       full_o
);
  acc_instr_t w_head;
  logic       w_push, w_issue, w_barrier, w_gate;
  logic       r_bubble;
  acc_fifo #(.DEPTH(DEPTH), .W($bits(acc_instr_t))) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_push),
    .pop_i   (w_issue),
    .data_i  (instr_i),
    .data_o  (w_head),
    .count_o (level_o),
    .empty_o (empty_o),
    .full_o  (full_o)
  );
  assign instr_ready_o     = !full_o && !flush_i;
  assign w_push            = instr_valid_i && instr_ready_o;
  assign w_barrier         = is_barrier_op(w_head);
  // Accelerator ops wait for the FPU to drain; vanilla ops only need FPU input space.
  assign w_gate            = w_barrier ? !fpu_busy_i : fpu_in_ready_i;
  assign w_issue           = !empty_o && !r_bubble && !flush_i && acc_idle_i && w_gate;
  assign acc_instr_valid_o = w_issue;
  assign acc_instr_o       = w_head;
  // Covers the cycle before acc_idle_i drops once an accelerator op starts.
  always_ff @(posedge clk_i)
    r_bubble <= (rst_i || flush_i) ? 1'b0 : (w_issue && w_barrier);
endmodule

// File: tb/tb_acc_instr_queue.sv
// tb_acc_instr_queue: directed and randomized checks of acc_instr_queue against a queue-based model.
module tb_acc_instr_queue;
  import acc_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst = 1'b1, instr_valid = 1'b0, flush = 1'b0;
  logic       acc_idle = 1'b0, fpu_busy = 1'b0, fpu_in_ready = 1'b0;
  logic       instr_ready, acc_instr_valid, empty, full;
  logic [2:0] level;
  acc_instr_t instr = '0, acc_instr;
  int n_checks = 0, n_fail = 0;
  acc_instr_t q[$];
  bit         m_bubble = 1'b0;
  logic       e_valid, e_ready, e_empty, e_full;
  logic [2:0] e_level;
  acc_instr_t e_head;

  acc_instr_queue #(.DEPTH(DEPTH)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .instr_i           (instr),
    .instr_valid_i     (instr_valid),
    .instr_ready_o     (instr_ready),
    .flush_i           (flush),
    .acc_instr_o       (acc_instr),
    .acc_instr_valid_o (acc_instr_valid),
    .acc_idle_i        (acc_idle),
    .fpu_busy_i        (fpu_busy),
    .fpu_in_ready_i    (fpu_in_ready),
    .level_o           (level),
    .empty_o           (empty),
    .full_o            (full)
  );

  function automatic acc_instr_t mk(input acc_opcode_e op, input logic [4:0] rd);
    acc_instr_t i;
    i.op     = op;
    i.rd     = rd;
    i.rs1    = 5'($urandom);
    i.rs2    = 5'($urandom);
    i.acc_op = op inside {OP_SET_W, OP_PREPIV, OP_PIV};
    return i;
  endfunction

  // Drives one cycle's inputs, computes expected outputs from the model, then advances the model.
  task automatic drive(input acc_instr_t ins, input logic v, input logic fl, input logic idle,
                       input logic busy, input logic rdy, input logic r);
    @(negedge clk);
    rst = r; instr = ins; instr_valid = v; flush = fl;
    acc_idle = idle; fpu_busy = busy; fpu_in_ready = rdy;
    #1;
    e_ready = (q.size() < DEPTH) && !fl;
    e_valid = (q.size() > 0) && !m_bubble && !fl && idle && (q[0].acc_op ? !busy : rdy);
    e_head  = (q.size() > 0) ? q[0] : '0;
    e_level = 3'(q.size());
    e_empty = q.size() == 0;
    e_full  = q.size() == DEPTH;
    if (r || fl) begin
      q.delete();
      m_bubble = 1'b0;
    end else begin
      m_bubble = e_valid && e_head.acc_op;
      if (e_valid) void'(q.pop_front());
      if (v && e_ready) q.push_back(ins);
    end
  endtask

  task automatic idle_cycle(input logic idle);
    drive(mk(OP_FADD, 0), 1'b0, 1'b0, idle, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_flush();
    drive(mk(OP_FADD, 0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    drive(mk(OP_FADD, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycle(1'b1);
    n_checks++; if (acc_instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", acc_instr_valid); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
  endtask

  task automatic test_vanilla_stream();
    logic [4:0] rds[$];
    int peak = 0;
    for (int c = 0; c < 6; c++) begin
      drive(mk(OP_FADD, 5'(c + 1)), c < 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      n_checks++; if (acc_instr_valid !== (c >= 1 && c <= 3)) begin n_fail++; $display("FAIL stream_pulse c=%0d got=%b exp=%b", c, acc_instr_valid, (c >= 1 && c <= 3)); end
      n_checks++; if (e_valid && acc_instr !== e_head) begin n_fail++; $display("FAIL stream_word c=%0d got=%h exp=%h", c, acc_instr, e_head); end
      if (acc_instr_valid === 1'b1) rds.push_back(acc_instr.rd);
      if (int'(level) > peak) peak = int'(level);
    end
    n_checks++; if (rds.size() != 3 || rds[0] !== 5'd1 || rds[1] !== 5'd2 || rds[2] !== 5'd3) begin n_fail++; $display("FAIL stream_order got=%p exp='{1,2,3}", rds); end
    n_checks++; if (peak != 1) begin n_fail++; $display("FAIL stream_peak got=%0d exp=1", peak); end
  endtask

  task automatic test_fill_wrap();
    for (int rep = 0; rep < 2; rep++) begin
      logic [4:0] rds[$];
      for (int i = 0; i < 5; i++) begin
        drive(mk(OP_FMUL, 5'(rep * 8 + i + 1)), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (instr_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_ready rep=%0d i=%0d got=%b exp=%b", rep, i, instr_ready, (i < 4)); end
      end
      n_checks++; if (full !== 1'b1 || level !== 3'd4) begin n_fail++; $display("FAIL fill_full rep=%0d got full=%b level=%0d exp full=1 level=4", rep, full, level); end
      for (int i = 0; i < 6; i++) begin
        idle_cycle(1'b1);
        n_checks++; if (acc_instr_valid !== e_valid) begin n_fail++; $display("FAIL drain_valid rep=%0d i=%0d got=%b exp=%b", rep, i, acc_instr_valid, e_valid); end
        if (acc_instr_valid === 1'b1) rds.push_back(acc_instr.rd);
      end
      n_checks++;
      if (rds.size() != 4 || rds[0] !== 5'(rep*8+1) || rds[1] !== 5'(rep*8+2) || rds[2] !== 5'(rep*8+3) || rds[3] !== 5'(rep*8+4)) begin
        n_fail++; $display("FAIL drain_order rep=%0d got=%p exp=%0d..%0d", rep, rds, rep*8+1, rep*8+4);
      end
    end
  endtask

  task automatic test_barrier();
    do_flush();
    drive(mk(OP_FMUL, 5), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(mk(OP_PIV, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycle(1'b1);
    n_checks++; if (acc_instr_valid !== 1'b1 || acc_instr.rd !== 5'd5) begin n_fail++; $display("FAIL barrier_fmul got v=%b rd=%0d exp v=1 rd=5", acc_instr_valid, acc_instr.rd); end
    for (int k = 0; k < 6; k++) begin
      drive(mk(OP_FADD, 7), k == 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++; if (acc_instr_valid !== 1'b0) begin n_fail++; $display("FAIL barrier_hold k=%0d got=%b exp=0", k, acc_instr_valid); end
    end
    idle_cycle(1'b1);
    n_checks++; if (acc_instr_valid !== 1'b1 || acc_instr.op !== OP_PIV) begin n_fail++; $display("FAIL barrier_piv got v=%b op=%0d exp v=1 op=%0d", acc_instr_valid, acc_instr.op, OP_PIV); end
    idle_cycle(1'b1);
    n_checks++; if (acc_instr_valid !== 1'b0) begin n_fail++; $display("FAIL barrier_bubble got=%b exp=0", acc_instr_valid); end
    idle_cycle(1'b1);
    n_checks++; if (acc_instr_valid !== 1'b1 || acc_instr.rd !== 5'd7) begin n_fail++; $display("FAIL barrier_fadd got v=%b rd=%0d exp v=1 rd=7", acc_instr_valid, acc_instr.rd); end
  endtask

  task automatic test_full_pop();
    do_flush();
    for (int i = 0; i < 4; i++) drive(mk(OP_FADD, 5'(i + 1)), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(mk(OP_FADD, 9), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++; if (instr_ready !== 1'b0 || acc_instr_valid !== 1'b1 || level !== 3'd4) begin n_fail++; $display("FAIL fullpop_cycle got rdy=%b v=%b lvl=%0d exp rdy=0 v=1 lvl=4", instr_ready, acc_instr_valid, level); end
    idle_cycle(1'b0);
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL fullpop_level got=%0d exp=3", level); end
    for (int i = 0; i < 5; i++) begin
      idle_cycle(1'b1);
      n_checks++; if (acc_instr_valid === 1'b1 && acc_instr.rd === 5'd9) begin n_fail++; $display("FAIL fullpop_refused got rd=9 exp absent"); end
    end
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < 3; i++) drive(mk(OP_FADD, 5'(i + 1)), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(mk(OP_FADD, 20), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++; if (acc_instr_valid !== 1'b0 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL flush_cycle got v=%b rdy=%b exp v=0 rdy=0", acc_instr_valid, instr_ready); end
    drive(mk(OP_FMUL, 21), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (empty !== 1'b1 || level !== 3'd0) begin n_fail++; $display("FAIL flush_empty got e=%b lvl=%0d exp e=1 lvl=0", empty, level); end
    idle_cycle(1'b1);
    n_checks++; if (acc_instr_valid !== 1'b1 || acc_instr.rd !== 5'd21) begin n_fail++; $display("FAIL flush_next got v=%b rd=%0d exp v=1 rd=21", acc_instr_valid, acc_instr.rd); end
  endtask

  task automatic test_reset_mid();
    do_flush();
    drive(mk(OP_FMUL, 3), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(mk(OP_PIV, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(mk(OP_FADD, 4), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycle(1'b1);
    drive(mk(OP_FADD, 0), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++; if (acc_instr_valid !== 1'b0 || level !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre got v=%b lvl=%0d exp v=0 lvl=2", acc_instr_valid, level); end
    drive(mk(OP_FADD, 0), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle_cycle(1'b1);
    n_checks++; if (acc_instr_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_post got v=%b e=%b exp v=0 e=1", acc_instr_valid, empty); end
    for (int i = 0; i < 3; i++) begin
      idle_cycle(1'b1);
      n_checks++; if (acc_instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet i=%0d got=%b exp=0", i, acc_instr_valid); end
    end
  endtask

  task automatic test_random();
    do_flush();
    for (int c = 0; c < 400; c++) begin
      drive(mk(acc_opcode_e'($urandom_range(0, 5)), 5'($urandom)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
            $urandom_range(0, 9) < 8, $urandom_range(0, 59) == 0);
      n_checks++; if (acc_instr_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, acc_instr_valid, e_valid); end
      n_checks++; if (e_valid && acc_instr !== e_head) begin n_fail++; $display("FAIL rnd_word c=%0d got=%h exp=%h", c, acc_instr, e_head); end
      n_checks++; if (instr_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, instr_ready, e_ready); end
      n_checks++; if (level !== e_level || empty !== e_empty || full !== e_full) begin n_fail++; $display("FAIL rnd_level c=%0d got lvl=%0d e=%b f=%b exp lvl=%0d e=%b f=%b", c, level, empty, full, e_level, e_empty, e_full); end
    end
  endtask

  initial begin
    test_reset();
    test_vanilla_stream();
    test_fill_wrap();
    test_barrier();
    test_full_pop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/acc_instr_queue.md
Name: acc_instr_queue

Overview:
- Issue buffer directly upstream of the accelerator controller.
- Accepts acc_instr_t words from the CPU side on a valid/ready handshake and holds them in a DEPTH-entry FIFO.
- Issues each word to the controller as a one-cycle valid pulse, and only when the controller and FPU can take it.
- Enforces a drain barrier before accelerator ops (SET_W/PREPIV/PIV), so pivot operations never read regfile entries with FPU writebacks still in flight.

Parameters:
- DEPTH, 4, number of queued instructions; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- instr_i  in  $bits(acc_instr_t)  instruction from CPU.
- instr_valid_i  in  1  instr_i valid.
- instr_ready_o  out  1  queue can accept; transfer when valid&&ready.
- flush_i  in  1  discard all queued, unissued entries.
- acc_instr_o  out  $bits(acc_instr_t)  head entry, to controller cpu_acc_instr_i.
- acc_instr_valid_o  out  1  one-cycle issue pulse, to controller cpu_acc_instr_valid_i.
- acc_idle_i  in  1  controller is in its FPU (idle) state.
- fpu_busy_i  in  1  FPU has data in flight.
- fpu_in_ready_i  in  1  FPU input ready.
- level_o  out  $clog2(DEPTH+1)  occupied entries.
- empty_o  out  1  level_o == 0.
- full_o  out  1  level_o == DEPTH.

Behaviour:
- Reset: all pointers and the count are 0, and the bubble flag is 0.
  - Output values at reset: acc_instr_valid_o=0, empty_o=1, full_o=0, level_o=0, instr_ready_o=1 (when flush_i is low).
  - acc_instr_o is don't-care while acc_instr_valid_o=0.
- Reset mid-operation: all queued entries are lost. In-flight FPU ops are outside this block and are not affected.
- Storage: circular buffer with wptr and rptr, each $clog2(DEPTH) bits, wrapping naturally at DEPTH-1 -> 0. A separate count register is $clog2(DEPTH+1) bits.
- Push condition: instr_valid_i && instr_ready_o. instr_ready_o = !full_o && !flush_i, decoded combinationally from registered count.
- Full: a push is refused even if a pop occurs in the same cycle. instr_ready_o is never a function of the pop decision.
- acc_instr_o is always driven from mem[rptr].
- Issue condition, evaluated each cycle when !empty_o && !bubble:
  - Vanilla FPU op (acc_op=0): issue if acc_idle_i && fpu_in_ready_i.
  - Accelerator op (acc_op=1): issue if acc_idle_i && !fpu_busy_i (barrier).
- Issue cycle: acc_instr_valid_o=1 for exactly that cycle, rptr increments and count decrements at the next edge.
- Bubble: after issuing an accelerator op, bubble=1 for the following cycle only and blocks issue. This covers the one-cycle lag before acc_idle_i falls when PIV starts.
- Latency: an entry pushed at cycle t is earliest issuable at t+1. There is no combinational bypass from instr_i to acc_instr_o.
- Simultaneous push and issue: count is unchanged and both pointers advance.
- Empty: acc_instr_valid_o=0. acc_instr_o holds a stale value and must not be used.
- Flush: at the next edge rptr=wptr=count=0 and bubble=0.
  - acc_instr_valid_o is forced 0 in a flush cycle, so no issue happens in that cycle.
  - A push offered in a flush cycle is not accepted.
- Throughput: back-to-back vanilla ops issue at 1 per cycle while the gating conditions hold.

Decomposition:
- acc_pkg: acc_instr_t (existing), ACC_QUEUE_DEPTH default constant, and function is_barrier_op(acc_instr_t) returning acc_op.
- Sub-module acc_fifo, a generic synchronous FIFO:
  - Ports: push, pop, data in, data out, count, empty, full, flush.
  - acc_instr_queue instantiates it and adds the issue/barrier/bubble logic.

Test Plan:
- Reset then push 3 vanilla ops (rd=1,2,3) with acc_idle_i=1, fpu_in_ready_i=1 -> pulses at cycles 1,2,3 in order rd 1,2,3; level_o peaks at 1.
- acc_idle_i=0, push 5 ops into DEPTH=4 -> 4 accepted, instr_ready_o=0 on the 5th, full_o=1, level_o=4. Raise acc_idle_i -> 4 pulses in FIFO order. Pointer wrap verified on a second fill.
- Queue [FMUL rd=5, PIV]; fpu_busy_i held 1 for 6 cycles after FMUL issue -> PIV pulse exactly in the first cycle fpu_busy_i=0. No pulse the following cycle (bubble) even with [FADD] queued behind.
- Full queue, push attempted in the same cycle as an issue -> push refused and level_o goes 4->3.
- 3 entries queued, flush_i=1 with instr_valid_i=1 -> no issue pulse that cycle; next cycle empty_o=1, level_o=0, and the pushed word is absent.
- Reset asserted while level_o=2 and a PIV is mid-barrier -> next cycle acc_instr_valid_o=0, empty_o=1, and no pulse afterward.
